// File: rtl/maze_mover.sv
`default_nettype none
// ============================================================================
//  Module   : maze_mover
//  Purpose  : Registered player-movement engine for the maze game. Owns the
//             player position and evaluates one move per 10 Hz tick while
//             playing. Handles hold-to-repeat on the direction buttons, keeps
//             a saturating step counter, pulses a wall-bump flag on refused
//             moves and raises a sticky arrival flag at the goal cell.
//  Ports    : clk, rst (async, active-high)
//             tick        - one-cycle move strobe
//             play        - game is in the playing state
//             start       - load start position (0,0), clear counters
//             map         - bit y*num+x is 1 for floor, 0 for wall
//             num         - active maze dimension
//             goal_x/y    - goal cell
//             up/down/left/right - debounced button levels
//             pos_x/y     - current position
//             arrived     - sticky goal-reached flag
//             steps       - legal moves taken (saturating)
//             bump        - one-cycle pulse on a refused move attempt
//  Revision : 1.0 - initial release
// ============================================================================
module maze_mover #(
  parameter int MAX_N         = 19,
  parameter int CW            = 5,
  parameter int IW            = 9,
  parameter int REPEAT_DELAY  = 5,
  parameter int REPEAT_PERIOD = 2,
  parameter int STEP_W        = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  input  logic                   play,
  input  logic                   start,
  input  logic [MAX_N*MAX_N-1:0] map,
  input  logic [CW-1:0]          num,
  input  logic [CW-1:0]          goal_x,
  input  logic [CW-1:0]          goal_y,
  input  logic                   up,
  input  logic                   down,
  input  logic                   left,
  input  logic                   right,
  output logic [CW-1:0]          pos_x,
  output logic [CW-1:0]          pos_y,
  output logic                   arrived,
  output logic [STEP_W-1:0]      steps,
  output logic                   bump
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_PLAY = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  localparam logic [2:0] c_DIR_NONE = 3'd0;
  localparam logic [2:0] c_DIR_U    = 3'd1;
  localparam logic [2:0] c_DIR_D    = 3'd2;
  localparam logic [2:0] c_DIR_L    = 3'd3;
  localparam logic [2:0] c_DIR_R    = 3'd4;

  localparam int c_REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int c_RC_W    = (c_REP_MAX < 2) ? 1 : $clog2(c_REP_MAX + 1);

  localparam logic [c_RC_W-1:0] c_RC_DELAY  = c_RC_W'(REPEAT_DELAY);
  localparam logic [c_RC_W-1:0] c_RC_PERIOD = c_RC_W'(REPEAT_PERIOD);
  localparam logic [c_RC_W-1:0] c_RC_ONE    = c_RC_W'(1);

  // One extra bit so a map of exactly 2^IW cells still compares correctly.
  localparam logic [IW:0] c_MAP_BITS = (IW+1)'(MAX_N * MAX_N);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [1:0]        r_state;
  logic [2:0]        r_prev_dir;
  logic [c_RC_W-1:0] r_rep_cnt;
  logic [CW-1:0]     r_pos_x;
  logic [CW-1:0]     r_pos_y;
  logic              r_arrived;
  logic [STEP_W-1:0] r_steps;
  logic              r_bump;

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  logic [1:0]        w_state_nxt;
  logic [2:0]        w_dir;
  logic              w_in_play;
  logic              w_goal_in_grid;
  logic              w_at_goal;
  logic              w_eval;
  logic              w_tick_eval;
  logic              w_new_press;
  logic              w_repeat;
  logic              w_attempt;
  logic [CW-1:0]     w_num_m1;
  logic              w_num_ok;
  logic [CW-1:0]     w_tx;
  logic [CW-1:0]     w_ty;
  logic              w_edge_ok;
  logic [IW-1:0]     w_idx;
  logic              w_idx_ok;
  logic              w_open;
  logic              w_legal;

  logic [2:0]        w_prev_dir_nxt;
  logic [c_RC_W-1:0] w_rep_cnt_nxt;
  logic [CW-1:0]     w_pos_x_nxt;
  logic [CW-1:0]     w_pos_y_nxt;
  logic              w_arrived_nxt;
  logic [STEP_W-1:0] w_steps_nxt;
  logic              w_bump_nxt;

  // --------------------------------------------------------------------------
  // Goal / evaluation qualifiers
  // --------------------------------------------------------------------------
  assign w_in_play      = (r_state == c_PLAY);
  // A goal outside the active grid can never be matched.
  assign w_goal_in_grid = (goal_x < num) && (goal_y < num);
  assign w_at_goal      = w_goal_in_grid && (r_pos_x == goal_x) && (r_pos_y == goal_y);
  // Arrival takes priority over a move in the same cycle.
  assign w_eval         = w_in_play && play && !w_at_goal;
  assign w_tick_eval    = w_eval && tick;

  // --------------------------------------------------------------------------
  // Direction select: up > down > left > right
  // --------------------------------------------------------------------------
  always_comb begin
    w_dir = c_DIR_NONE;
    if (up)
      w_dir = c_DIR_U;
    else if (down)
      w_dir = c_DIR_D;
    else if (left)
      w_dir = c_DIR_L;
    else if (right)
      w_dir = c_DIR_R;
  end

  // --------------------------------------------------------------------------
  // Hold-to-repeat qualification
  // --------------------------------------------------------------------------
  assign w_new_press = (w_dir != c_DIR_NONE) && (w_dir != r_prev_dir);
  assign w_repeat    = (w_dir != c_DIR_NONE) && (w_dir == r_prev_dir) && (r_rep_cnt == c_RC_ONE);
  assign w_attempt   = w_tick_eval && (w_new_press || w_repeat);

  // --------------------------------------------------------------------------
  // Target cell and legality
  // --------------------------------------------------------------------------
  assign w_num_m1 = num - CW'(1);
  assign w_num_ok = (num >= CW'(2)) && (num <= CW'(MAX_N));

  always_comb begin
    w_tx      = r_pos_x;
    w_ty      = r_pos_y;
    w_edge_ok = 1'b0;
    case (w_dir)
      c_DIR_U: begin
        w_ty      = r_pos_y - CW'(1);
        w_edge_ok = (r_pos_y != '0);
      end
      c_DIR_D: begin
        w_ty      = r_pos_y + CW'(1);
        w_edge_ok = (r_pos_y != w_num_m1);
      end
      c_DIR_L: begin
        w_tx      = r_pos_x - CW'(1);
        w_edge_ok = (r_pos_x != '0);
      end
      c_DIR_R: begin
        w_tx      = r_pos_x + CW'(1);
        w_edge_ok = (r_pos_x != w_num_m1);
      end
      default: begin
        w_tx      = r_pos_x;
        w_ty      = r_pos_y;
        w_edge_ok = 1'b0;
      end
    endcase
  end

  // Row-major index into the map, computed at IW bits on zero-extended values.
  assign w_idx    = (IW'(w_ty) * IW'(num)) + IW'(w_tx);
  // Guards the bit select if a caller leaves the player beyond a shrunk grid.
  assign w_idx_ok = ({1'b0, w_idx} < c_MAP_BITS);
  assign w_open   = w_idx_ok && map[w_idx];
  assign w_legal  = w_edge_ok && w_num_ok && w_open;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= c_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    if (start) begin
      w_state_nxt = c_PLAY;
    end else begin
      case (r_state)
        c_IDLE: if (play) w_state_nxt = c_PLAY;
        c_PLAY: begin
          if (!play)
            w_state_nxt = c_IDLE;
          else if (w_at_goal)
            w_state_nxt = c_DONE;
        end
        c_DONE: if (!play) w_state_nxt = c_IDLE;
        default: w_state_nxt = c_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FSM: output logic (next values of the registered outputs)
  // --------------------------------------------------------------------------
  always_comb begin
    w_prev_dir_nxt = r_prev_dir;
    w_rep_cnt_nxt  = r_rep_cnt;
    w_pos_x_nxt    = r_pos_x;
    w_pos_y_nxt    = r_pos_y;
    w_arrived_nxt  = r_arrived;
    w_steps_nxt    = r_steps;
    w_bump_nxt     = 1'b0;

    if (start) begin
      w_prev_dir_nxt = c_DIR_NONE;
      w_rep_cnt_nxt  = '0;
      w_pos_x_nxt    = '0;
      w_pos_y_nxt    = '0;
      w_arrived_nxt  = 1'b0;
      w_steps_nxt    = '0;
    end else if (!w_in_play) begin
      // Outside PLAY a held button must count as a fresh press on re-entry.
      w_prev_dir_nxt = c_DIR_NONE;
      w_rep_cnt_nxt  = '0;
    end else if (play && w_at_goal) begin
      w_arrived_nxt = 1'b1;
    end else if (w_tick_eval) begin
      w_prev_dir_nxt = w_dir;
      if (w_dir != c_DIR_NONE) begin
        if (w_new_press)
          w_rep_cnt_nxt = c_RC_DELAY;
        else if (w_repeat)
          w_rep_cnt_nxt = c_RC_PERIOD;
        else
          w_rep_cnt_nxt = r_rep_cnt - c_RC_ONE;
      end
      if (w_attempt) begin
        if (w_legal) begin
          w_pos_x_nxt = w_tx;
          w_pos_y_nxt = w_ty;
          if (r_steps != '1)
            w_steps_nxt = r_steps + STEP_W'(1);
        end else begin
          w_bump_nxt = 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_dir <= c_DIR_NONE;
      r_rep_cnt  <= '0;
      r_pos_x    <= '0;
      r_pos_y    <= '0;
      r_arrived  <= 1'b0;
      r_steps    <= '0;
      r_bump     <= 1'b0;
    end else begin
      r_prev_dir <= w_prev_dir_nxt;
      r_rep_cnt  <= w_rep_cnt_nxt;
      r_pos_x    <= w_pos_x_nxt;
      r_pos_y    <= w_pos_y_nxt;
      r_arrived  <= w_arrived_nxt;
      r_steps    <= w_steps_nxt;
      r_bump     <= w_bump_nxt;
    end
  end

  assign pos_x   = r_pos_x;
  assign pos_y   = r_pos_y;
  assign arrived = r_arrived;
  assign steps   = r_steps;
  assign bump    = r_bump;

endmodule
`default_nettype wire
